// File: rtl/range_fixer.sv
// Registered floored-mod-100 normaliser: signed 10-bit in, 0..99 out.
// One cycle latency, no handshake, synchronous active-high reset.
module range_fixer (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] nf_val,
    output logic [6:0] adj_val
);

    logic       neg;
    logic [9:0] mag;
    logic [9:0] r400;
    logic [9:0] r200;
    logic [9:0] r100a;
    logic [9:0] r100b;
    logic [9:0] res;

    assign neg = nf_val[9];

    // -512 has magnitude 512, which needs the full 10 unsigned bits
    assign mag = neg ? (~nf_val + 10'd1) : nf_val;

    assign r400  = (mag   >= 10'd400) ? (mag   - 10'd400) : mag;
    assign r200  = (r400  >= 10'd200) ? (r400  - 10'd200) : r400;
    assign r100a = (r200  >= 10'd100) ? (r200  - 10'd100) : r200;
    assign r100b = (r100a >= 10'd100) ? (r100a - 10'd100) : r100a;

    assign res = (neg && (r100b != 10'd0)) ? (10'd100 - r100b) : r100b;

    always_ff @(posedge clk) begin
        if (rst) begin
            adj_val <= 7'd0;
        end else begin
            adj_val <= res[6:0];
        end
    end

endmodule

// File: tb/tb_range_fixer.sv
// Directed and exhaustive checks for range_fixer against a floored-mod model.
module tb_range_fixer;

    logic       clk;
    logic       rst;
    logic [9:0] nf_val;
    logic [6:0] adj_val;

    int checks = 0;
    int errors = 0;

    range_fixer dut (
        .clk     (clk),
        .rst     (rst),
        .nf_val  (nf_val),
        .adj_val (adj_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_mod(input logic [9:0] v);
        logic signed [9:0] s;
        int sv;
        int r;
        s  = v;
        sv = s;
        r  = sv % 100;
        if (r < 0) r += 100;
        return r;
    endfunction

    // drive right after an edge, then look just after the next edge
    task automatic step(input string tag, input logic [9:0] v, input int exp);
        nf_val = v;
        @(posedge clk);
        #1;
        check(tag, int'(adj_val), exp);
    endtask

    typedef struct {
        logic [9:0] v;
        int         exp;
    } vec_t;

    vec_t vecs[11];
    vec_t b2b[3];
    int   prev;

    initial begin
        vecs[0]  = '{10'd0,   0};
        vecs[1]  = '{10'd45,  45};
        vecs[2]  = '{10'd99,  99};
        vecs[3]  = '{10'd100, 0};
        vecs[4]  = '{10'd250, 50};
        vecs[5]  = '{10'd511, 11};
        vecs[6]  = '{10'h3FF, 99};
        vecs[7]  = '{10'h39C, 0};
        vecs[8]  = '{10'h388, 80};
        vecs[9]  = '{10'h200, 88};
        vecs[10] = '{10'd685, 61};
        b2b[0]   = '{10'd45,  45};
        b2b[1]   = '{10'h388, 80};
        b2b[2]   = '{10'd685, 61};

        rst    = 1'b1;
        nf_val = 10'd45;
        @(posedge clk);
        #1;
        check("reset_c1", int'(adj_val), 0);
        @(posedge clk);
        #1;
        check("reset_c2", int'(adj_val), 0);

        rst = 1'b0;
        step("reset_release", 10'd45, 45);

        for (int i = 0; i < 11; i++) begin
            step($sformatf("vec_%0d", i), vecs[i].v, vecs[i].exp);
        end

        // mid-stream reset discards the value sampled at that edge
        rst = 1'b1;
        step("mid_reset", 10'd250, 0);
        rst = 1'b0;
        step("post_reset", 10'd250, 50);

        // back-to-back: output holds previous result until the next edge
        prev = 50;
        for (int i = 0; i < 3; i++) begin
            nf_val = b2b[i].v;
            @(negedge clk);
            check($sformatf("b2b_hold_%0d", i), int'(adj_val), prev);
            @(posedge clk);
            #1;
            check($sformatf("b2b_%0d", i), int'(adj_val), b2b[i].exp);
            prev = b2b[i].exp;
        end

        for (int i = 0; i < 1024; i++) begin
            logic [9:0] v;
            v = 10'(i);
            step($sformatf("sweep_%0d", i), v, ref_mod(v));
            check($sformatf("sweep_le99_%0d", i), int'(adj_val <= 7'd99), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
